// File: rtl/seg7_scan4.sv
// seg7_scan4: 4-digit multiplexed seven-segment scanner with double-buffered
// display data and inter-digit blanking. Active-low selects and segments.
// Optional leading-zero blanking is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan4 #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        en,
  output logic        pending,
  output logic        frame_start,
  output logic [3:0]  sel_out,
  output logic [7:0]  seg_out
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(BLANK_CYC + 1);
  localparam int unsigned AW = 20;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] shadow_q, shadow_d;
  logic [AW-1:0] active_q, active_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic          wrap;
  logic          blank;
  logic [3:0]    nib;
  logic          dp_bit;
  logic [3:0]    supp;

  // Hex digit to active-high a..g segments.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // Leading-zero suppression mask derived from the displayed (active) data only.
  always_comb begin
    supp    = 4'b0000;
    supp[3] = (active_q[15:12] == 4'h0) && !active_q[19];
    supp[2] = supp[3] && (active_q[11:8] == 4'h0) && !active_q[18];
    supp[1] = supp[2] && (active_q[7:4]  == 4'h0) && !active_q[17];
  end
`else
  assign supp = 4'b0000;
`endif

  // Next-state logic for scan timing, buffering and the output register.
  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    slot_cnt_d    = slot_cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;
    sel_d         = 4'hF;
    seg_d         = 8'hFF;

    tick  = (tick_cnt_q == TW'(TICK_DIV - 1));
    wrap  = tick && (idx_q == 2'd3);
    blank = (slot_cnt_q < SW'(BLANK_CYC));

    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    if (tick) begin
      idx_d      = idx_q + 2'd1;
      slot_cnt_d = '0;
    end else if (slot_cnt_q != SW'(BLANK_CYC)) begin
      slot_cnt_d = slot_cnt_q + SW'(1);
    end

    if (load) begin
      shadow_d  = {dp_in, value_in};
      pending_d = 1'b1;
    end

    // Display data only changes at the frame boundary, so a frame never tears.
    if (wrap) begin
      frame_start_d = 1'b1;
      if (load) begin
        active_d  = {dp_in, value_in};
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    nib    = active_q[{idx_q, 2'b00} +: 4];
    dp_bit = active_q[5'd16 + 5'(idx_q)];
    seg_d  = ~{dp_bit, hex7(nib)};
    if (!blank && en && !supp[idx_q]) begin
      sel_d = ~(4'b0001 << idx_q);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      slot_cnt_q    <= '0;
      idx_q         <= 2'd0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      sel_q         <= 4'hF;
      seg_q         <= 8'hFF;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign sel_out     = sel_q;
  assign seg_out     = seg_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4 with TICK_DIV=4, BLANK_CYC=1.
// Honours SEG7_LZ_BLANK_EN when the design is built with it.
module tb_seg7_scan4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        en;
  logic        pending;
  logic        frame_start;
  logic [3:0]  sel_out;
  logic [7:0]  seg_out;

  int checks   = 0;
  int failures = 0;
  int n;
  logic [3:0] supp;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fs;
    logic       pend;
  } vec_t;

  vec_t       tbl[16];
  logic [7:0] exp_a[4];

  seg7_scan4 #(.TICK_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
    .en(en), .pending(pending), .frame_start(frame_start),
    .sel_out(sel_out), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
    end
  endtask

  // Expected select after edge nn: slot phase 0 is the blanked cycle.
  function automatic logic [3:0] exp_sel(input int nn, input logic e, input logic [3:0] s);
    int d;
    d = (nn / 4) % 4;
    if ((nn % 4 == 0) || !e || s[d]) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  task automatic cyc();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic step();
    cyc();
    chk("sel", 32'(sel_out), 32'(exp_sel(n, en, supp)));
    chk("frame_start", 32'(frame_start), 32'(n % 16 == 15));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b1; value_in = 16'h0; dp_in = 4'h0;
    supp = 4'b0000; n = 0;

    // Idle frame after reset, hand-written.
    tbl[0]  = '{4'hF, 8'hC0, 1'b0, 1'b0};
    tbl[1]  = '{4'hE, 8'hC0, 1'b0, 1'b0};
    tbl[2]  = '{4'hE, 8'hC0, 1'b0, 1'b0};
    tbl[3]  = '{4'hE, 8'hC0, 1'b0, 1'b0};
    tbl[4]  = '{4'hF, 8'hC0, 1'b0, 1'b0};
    tbl[5]  = '{4'hD, 8'hC0, 1'b0, 1'b0};
    tbl[6]  = '{4'hD, 8'hC0, 1'b0, 1'b0};
    tbl[7]  = '{4'hD, 8'hC0, 1'b0, 1'b0};
    tbl[8]  = '{4'hF, 8'hC0, 1'b0, 1'b0};
    tbl[9]  = '{4'hB, 8'hC0, 1'b0, 1'b0};
    tbl[10] = '{4'hB, 8'hC0, 1'b0, 1'b0};
    tbl[11] = '{4'hB, 8'hC0, 1'b0, 1'b0};
    tbl[12] = '{4'hF, 8'hC0, 1'b0, 1'b0};
    tbl[13] = '{4'h7, 8'hC0, 1'b0, 1'b0};
    tbl[14] = '{4'h7, 8'hC0, 1'b0, 1'b0};
    tbl[15] = '{4'h7, 8'hC0, 1'b1, 1'b0};
`ifdef SEG7_LZ_BLANK_EN
    for (int i = 4; i < 16; i++) tbl[i].sel = 4'hF;
`endif
    exp_a[0] = 8'h0E; exp_a[1] = 8'h88; exp_a[2] = 8'hA4; exp_a[3] = 8'hF9;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel_out), 32'h0000_000F);
    chk("rst_seg", 32'(seg_out), 32'h0000_00FF);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    n = -1;

    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("tbl_sel", 32'(sel_out), 32'(tbl[i].sel));
      chk("tbl_seg", 32'(seg_out), 32'(tbl[i].seg));
      chk("tbl_fs", 32'(frame_start), 32'(tbl[i].fs));
      chk("tbl_pend", 32'(pending), 32'(tbl[i].pend));
    end
`ifdef SEG7_LZ_BLANK_EN
    supp = 4'b1110;
`endif

    // Mid-frame load while idx==1; shown only after the next wrap.
    repeat (4) step();
    load = 1'b1; value_in = 16'h12AF; dp_in = 4'b0001;
    step();
    load = 1'b0;
    chk("mid_pend_set", 32'(pending), 32'h1);
    repeat (10) step();
    chk("mid_pend_hold", 32'(pending), 32'h1);
    chk("mid_old_seg", 32'(seg_out), 32'h0000_00C0);
    step();
    chk("mid_pend_clr", 32'(pending), 32'h0);
    supp = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      step();
      if (n % 4 == 1) chk("load_seg", 32'(seg_out), 32'(exp_a[(n / 4) % 4]));
    end

    // Load coinciding with the idx==3 tick goes straight to active.
    load = 1'b1; value_in = 16'h8888; dp_in = 4'b0000;
    step();
    load = 1'b0;
    chk("wrap_pend", 32'(pending), 32'h0);
    for (int i = 0; i < 16; i++) begin
      load = (n + 1 == 52) || (n + 1 == 56);
      value_in = (n + 1 == 52) ? 16'h1111 : 16'h2222;
      step();
      load = 1'b0;
      if (n % 4 == 1) chk("wrap_seg", 32'(seg_out), 32'h0000_0080);
      if (n == 48) chk("wrap_pend_next", 32'(pending), 32'h0);
      if (n == 52 || n == 62) chk("repeat_pend", 32'(pending), 32'h1);
    end
    chk("repeat_pend_clr", 32'(pending), 32'h0);

    // Two frames disabled: selects idle, scan and frame_start continue.
    en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (n % 4 == 2) chk("en_seg", 32'(seg_out), 32'h0000_00A4);
    end
    en = 1'b1;
    repeat (4) step();
    chk("en_resume_seg", 32'(seg_out), 32'h0000_00A4);

    // Reset at idx==2 with data pending.
    load = 1'b1; value_in = 16'h5555; dp_in = 4'b1111;
    step();
    load = 1'b0;
    chk("pre_rst_pend", 32'(pending), 32'h1);
    repeat (4) step();
    rst = 1'b1;
    cyc();
    chk("mid_rst_sel", 32'(sel_out), 32'h0000_000F);
    chk("mid_rst_seg", 32'(seg_out), 32'h0000_00FF);
    chk("mid_rst_pend", 32'(pending), 32'h0);
    chk("mid_rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    n = -1;
`ifdef SEG7_LZ_BLANK_EN
    supp = 4'b1110;
`endif
    for (int i = 0; i < 20; i++) begin
      step();
      if (n % 4 == 1) chk("post_rst_seg", 32'(seg_out), 32'h0000_00C0);
      if (n == 15 || n == 19) chk("post_rst_pend", 32'(pending), 32'h0);
    end

`ifdef SEG7_LZ_BLANK_EN
    // Leading zeros of 0040 suppress slots 3 and 2.
    load = 1'b1; value_in = 16'h0040; dp_in = 4'b0000;
    step();
    load = 1'b0;
    repeat (11) step();
    supp = 4'b1100;
    repeat (16) begin
      step();
      if (n == 33) chk("lz_d0", 32'(seg_out), 32'h0000_00C0);
      if (n == 37) chk("lz_d1", 32'(seg_out), 32'h0000_0099);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
